// File: rtl/i2c_pkg.sv
// Shared types and default sizing for the I2C register-map controller.
package i2c_pkg;
  localparam int         NREGS_DEF   = 16;
  localparam int         AW_DEF      = 4;
  localparam logic [7:0] RST_VAL_DEF = 8'h00;

  typedef enum logic [1:0] {IDLE, PTR, WR, RD} state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// 2-flop synchroniser for an SCL-domain flag plus a single-cycle rise or fall detect.
module i2c_sync_edge #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic start_async_rst,
  input  logic d,
  output logic edge_det
);
  // sh[1] is the synchronised level, sh[2] its one-cycle-delayed copy
  logic [2:0] sh;

  always_ff @(posedge clk or posedge start_async_rst)
    if (start_async_rst) sh <= '0;
    else                 sh <= {sh[1:0], d};

  assign edge_det = FALL ? (~sh[1] & sh[2]) : (sh[1] & ~sh[2]);
endmodule

// File: rtl/i2c_regmap_ctrl.sv
// I2C register-map controller: pointer/data sequencing plus host/I2C register-file arbitration.
// Define I2C_CTRL_WRAP_EN to wrap the pointer at NREGS-1 instead of saturating.
module i2c_regmap_ctrl
  import i2c_pkg::*;
#(
  parameter int         NREGS   = NREGS_DEF,
  parameter int         AW      = AW_DEF,
  parameter logic [7:0] RST_VAL = RST_VAL_DEF
) (
  input  logic          clk,
  input  logic          start_async_rst,
  input  logic          i2c_start,
  input  logic          i2c_stop,
  input  logic          i2c_r_w,
  input  logic          i2c_data_vld,
  input  logic [7:0]    i2c_data_out,
  output logic [7:0]    i2c_data_in,
  output logic          i2c_ready,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_ack,
  output logic [AW-1:0] ptr,
  output logic          busy
);
  logic start_r, stop_r, byte_done;

  i2c_sync_edge #(.FALL(1'b0)) u_start (.clk(clk), .start_async_rst(start_async_rst), .d(i2c_start),    .edge_det(start_r));
  i2c_sync_edge #(.FALL(1'b0)) u_stop  (.clk(clk), .start_async_rst(start_async_rst), .d(i2c_stop),     .edge_det(stop_r));
  i2c_sync_edge #(.FALL(1'b1)) u_vld   (.clk(clk), .start_async_rst(start_async_rst), .d(i2c_data_vld), .edge_det(byte_done));

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 commit, grant, rdy_q;
  logic [NREGS-1:0][7:0] regs;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
`ifdef I2C_CTRL_WRAP_EN
    return p + 1'b1;
`else
    return (p == {AW{1'b1}}) ? p : p + 1'b1;
`endif
  endfunction

  always_ff @(posedge clk or posedge start_async_rst)
    if (start_async_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdy_q   <= 1'b1;
    end

  // byte is handled before any START/STOP seen in the same cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    commit  = 1'b0;
    if (byte_done) begin
      case (state_q)
        PTR: begin
          if (i2c_r_w) begin
            ptr_d   = ptr_inc(ptr_q);
            state_d = RD;
          end else begin
            ptr_d   = i2c_data_out[AW-1:0];
            state_d = WR;
          end
        end
        WR: begin
          commit = 1'b1;
          ptr_d  = ptr_inc(ptr_q);
        end
        RD:      ptr_d = ptr_inc(ptr_q);
        default: ;
      endcase
    end
    if (start_r) state_d = PTR;
    if (stop_r)  state_d = IDLE;
  end

  // I2C commit owns the single port; host waits one cycle when they collide
  assign grant = host_req & ~host_ack & ~commit;

  always_ff @(posedge clk or posedge start_async_rst)
    if (start_async_rst) begin
      regs        <= {NREGS{RST_VAL}};
      host_ack    <= 1'b0;
      host_rdata  <= 8'h00;
      i2c_data_in <= 8'h00;
    end else begin
      host_ack    <= grant;
      if (grant) host_rdata <= regs[host_addr];
      if (commit)                 regs[ptr_q]     <= i2c_data_out;
      else if (grant && host_we)  regs[host_addr] <= host_wdata;
      i2c_data_in <= regs[ptr_q];
    end

  assign i2c_ready = rdy_q & ~commit;
  assign ptr       = ptr_q;
  assign busy      = (state_q != IDLE);
endmodule
